// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between N_REQ byte sources.
// Handles the tx_enable/tx_status handshake and flags a sticky error if the UART never starts.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned BUSY_TIMEOUT = 1023
) (
  input  logic                 sysclk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic [7:0]           tx_data,
  output logic                 tx_enable,
  input  logic                 tx_status,
  output logic                 busy,
  output logic [2:0]           owner,
  output logic                 timeout_err,
  input  logic                 err_clr
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        owner_q, owner_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [10:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              timeout_err_q, timeout_err_d;
  logic              tmo_set;

  logic [7:0]        req_ext;
  logic [3:0]        scan_idx;
  logic [3:0]        nxt_ptr;
  logic              found;
  logic [2:0]        win_idx;
  logic [7:0]        win_byte;
  logic [N_REQ-1:0]  owner_onehot;

  // Scan upward from ptr with wrap-around; first requester seen wins.
  always_comb begin
    req_ext                = '0;
    req_ext[N_REQ-1:0]     = req;
    found                  = 1'b0;
    win_idx                = '0;
    scan_idx               = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = {1'b0, ptr_q} + 4'(k);
      if (scan_idx >= 4'(N_REQ)) scan_idx = scan_idx - 4'(N_REQ);
      if (!found && req_ext[scan_idx[2:0]]) begin
        found   = 1'b1;
        win_idx = scan_idx[2:0];
      end
    end
    win_byte = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (3'(i) == win_idx) win_byte = req_data[8*i +: 8];
    end
    nxt_ptr = {1'b0, win_idx} + 4'd1;
    if (nxt_ptr == 4'(N_REQ)) nxt_ptr = '0;
  end

  always_comb begin
    owner_onehot = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (3'(i) == owner_q) owner_onehot[i] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    tx_data_d = tx_data_q;
    cnt_d     = cnt_q;
    done_d    = '0;
    tmo_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && tx_status) begin
          state_d   = ISSUE;
          owner_d   = win_idx;
          tx_data_d = win_byte;
          ptr_d     = nxt_ptr[2:0];
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        cnt_d   = '0;
      end
      WAIT_BUSY: begin
        if (!tx_status) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == 11'(BUSY_TIMEOUT)) begin
          tmo_set = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      WAIT_DONE: begin
        if (tx_status) begin
          done_d  = owner_onehot;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new timeout takes priority over a clear in the same cycle.
    if (tmo_set)      timeout_err_d = 1'b1;
    else if (err_clr) timeout_err_d = 1'b0;
    else              timeout_err_d = timeout_err_q;
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      tx_data_q     <= '0;
      cnt_q         <= '0;
      done_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      tx_data_q     <= tx_data_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = (state_q == ISSUE) ? owner_onehot : '0;
  assign tx_enable   = (state_q == ISSUE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign owner       = owner_q;
  assign tx_data     = tx_data_q;
  assign timeout_err = timeout_err_q;

endmodule
